// File: rtl/gpio_in_parity_monitor.sv
// GPIO input parity monitor.
// Synchronises the 17-bit loopback bus (16 data bits plus a parity bit) and
// captures every change of the synchronised value. Each captured sample is
// parity-checked and queued in a first-word fall-through FIFO. A sticky error
// flag and a saturating error counter make injected loopback errors visible.
module gpio_in_parity_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [16:0]                   GPIO_IN,
  input  logic                          enable,
  input  logic                          clr_err,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [15:0]                   rd_data,
  output logic                          rd_perr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_sticky,
  output logic [CNT_W-1:0]              err_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [16:0] s;

  // SYNC_STAGES=0 feeds the bus straight through; otherwise a flop chain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = GPIO_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][16:0] sync_q;

      // Shift the raw bus through the synchroniser chain.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= GPIO_IN;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [16:0] last_q;
  logic        capture;
  logic        perr;

  // last_q tracks s even while disabled, so re-enabling never fires a stale change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= '0;
    else          last_q <= s;
  end

  assign capture = enable && (s != last_q);
  assign perr    = (^s) != PARITY_ODD;

  // FIFO storage and pointers.
  logic [16:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign rd_valid = (level_q != '0);
  assign pop      = rd_valid && rd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = capture && (!full || pop);
  assign drop     = capture && full && !pop;

  // Pointer and level next-state; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointer/level registers; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage write; contents need no reset because level gates the read side.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {perr, s[15:0]};
  end

  assign rd_data    = rd_valid ? mem_q[rd_ptr_q][15:0] : 16'h0000;
  assign rd_perr    = rd_valid ? mem_q[rd_ptr_q][16]   : 1'b0;
  assign fifo_level = level_q;

  // Error tracking.
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_sticky_q, err_sticky_d;
  logic             overflow_q, overflow_d;

  // clr_err outranks any same-cycle error or overflow event.
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    overflow_d   = overflow_q;
    if (clr_err) begin
      err_count_d  = '0;
      err_sticky_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (capture && perr) begin
        err_sticky_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      end
      if (drop) overflow_d = 1'b1;
    end
  end

  // Error register bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
      overflow_q   <= overflow_d;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;
  assign overflow   = overflow_q;

endmodule
